// File: rtl/tlb_op_ctrl_if.sv
// Signal bundle between the TLB op sequencer, the CP0/memory stages and the tlb array.
// slave = sequencer view, master = surrounding pipeline/array view.
interface tlb_op_ctrl_if #(
  parameter int TLBNUM = 16
);
  localparam int IW = $clog2(TLBNUM);

  logic          req_valid;
  logic [1:0]    req_op;
  logic          req_ready;
  logic          done;

  logic [18:0]   cp0_vpn2;
  logic [7:0]    cp0_asid;
  logic          cp0_g;
  logic [19:0]   cp0_pfn0;
  logic [2:0]    cp0_c0;
  logic          cp0_d0;
  logic          cp0_v0;
  logic [19:0]   cp0_pfn1;
  logic [2:0]    cp0_c1;
  logic          cp0_d1;
  logic          cp0_v1;
  logic [IW-1:0] cp0_index;
  logic [IW-1:0] cp0_wired;
  logic          wired_we;
  logic [IW-1:0] random;

  logic [18:0]   mem_vpn2;
  logic          mem_odd_page;
  logic [7:0]    mem_asid;
  logic          mem_stall;

  logic [18:0]   s1_vpn2;
  logic          s1_odd_page;
  logic [7:0]    s1_asid;
  logic          s1_found;
  logic [IW-1:0] s1_index;

  logic          we;
  logic [IW-1:0] w_index;
  logic [18:0]   w_vpn2;
  logic [7:0]    w_asid;
  logic          w_g;
  logic [19:0]   w_pfn0;
  logic [2:0]    w_c0;
  logic          w_d0;
  logic          w_v0;
  logic [19:0]   w_pfn1;
  logic [2:0]    w_c1;
  logic          w_d1;
  logic          w_v1;

  logic [IW-1:0] r_index;

  logic          idx_we;
  logic          idx_p;
  logic [IW-1:0] idx_value;
  logic          tlbr_we;

  modport slave (
    input  req_valid, req_op,
    output req_ready, done,
    input  cp0_vpn2, cp0_asid, cp0_g,
    input  cp0_pfn0, cp0_c0, cp0_d0, cp0_v0,
    input  cp0_pfn1, cp0_c1, cp0_d1, cp0_v1,
    input  cp0_index, cp0_wired, wired_we,
    output random,
    input  mem_vpn2, mem_odd_page, mem_asid,
    output mem_stall,
    output s1_vpn2, s1_odd_page, s1_asid,
    input  s1_found, s1_index,
    output we, w_index, w_vpn2, w_asid, w_g,
    output w_pfn0, w_c0, w_d0, w_v0,
    output w_pfn1, w_c1, w_d1, w_v1,
    output r_index,
    output idx_we, idx_p, idx_value, tlbr_we
  );

  modport master (
    output req_valid, req_op,
    input  req_ready, done,
    output cp0_vpn2, cp0_asid, cp0_g,
    output cp0_pfn0, cp0_c0, cp0_d0, cp0_v0,
    output cp0_pfn1, cp0_c1, cp0_d1, cp0_v1,
    output cp0_index, cp0_wired, wired_we,
    input  random,
    output mem_vpn2, mem_odd_page, mem_asid,
    input  mem_stall,
    input  s1_vpn2, s1_odd_page, s1_asid,
    output s1_found, s1_index,
    input  we, w_index, w_vpn2, w_asid, w_g,
    input  w_pfn0, w_c0, w_d0, w_v0,
    input  w_pfn1, w_c1, w_d1, w_v1,
    input  r_index,
    input  idx_we, idx_p, idx_value, tlbr_we
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR: 3 cycles accept-to-accept, req_ready only in IDLE.
// Owns CP0 Random and borrows tlb search port 1 from the memory stage during a probe.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16
) (
  input  logic            clk,
  input  logic            reset,
  tlb_op_ctrl_if.slave    bus
);
  localparam int IW = $clog2(TLBNUM);
  localparam logic [IW-1:0] RAND_TOP = IW'(TLBNUM - 1);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  entry_t        ent_q, ent_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          found_q, found_d;
  logic [IW-1:0] pidx_q, pidx_d;
  logic [IW-1:0] random_q, random_d;

  logic          req_ready_c;
  logic          done_c;
  logic          we_c;
  logic          idx_we_c;
  logic          tlbr_we_c;
  logic          probe_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      ent_q    <= '0;
      idx_q    <= '0;
      found_q  <= 1'b0;
      pidx_q   <= '0;
      random_q <= RAND_TOP;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ent_q    <= ent_d;
      idx_q    <= idx_d;
      found_q  <= found_d;
      pidx_q   <= pidx_d;
      random_q <= random_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ent_d       = ent_q;
    idx_d       = idx_q;
    found_d     = found_q;
    pidx_d      = pidx_q;
    req_ready_c = 1'b0;
    done_c      = 1'b0;
    we_c        = 1'b0;
    idx_we_c    = 1'b0;
    tlbr_we_c   = 1'b0;
    probe_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          op_d       = bus.req_op;
          ent_d.vpn2 = bus.cp0_vpn2;
          ent_d.asid = bus.cp0_asid;
          ent_d.g    = bus.cp0_g;
          ent_d.pfn0 = bus.cp0_pfn0;
          ent_d.c0   = bus.cp0_c0;
          ent_d.d0   = bus.cp0_d0;
          ent_d.v0   = bus.cp0_v0;
          ent_d.pfn1 = bus.cp0_pfn1;
          ent_d.c1   = bus.cp0_c1;
          ent_d.d1   = bus.cp0_d1;
          ent_d.v1   = bus.cp0_v1;
          // TLBWR targets the Random value seen at accept, not the one during WRITE
          idx_d      = (bus.req_op == OP_TLBWR) ? random_q : bus.cp0_index;
          case (bus.req_op)
            OP_TLBP:  state_d = S_PROBE;
            OP_TLBR:  state_d = S_READ;
            default:  state_d = S_WRITE;
          endcase
        end
      end
      S_PROBE: begin
        probe_c = 1'b1;
        found_d = bus.s1_found;
        pidx_d  = bus.s1_index;
        state_d = S_DONE;
      end
      S_READ: begin
        state_d = S_DONE;
      end
      S_WRITE: begin
        we_c    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_c    = 1'b1;
        idx_we_c  = (op_q == OP_TLBP);
        tlbr_we_c = (op_q == OP_TLBR);
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    random_d = random_q - 1'b1;
    if (bus.wired_we || (random_q <= bus.cp0_wired) || (random_q == '0)) begin
      random_d = RAND_TOP;
    end
  end

  // Reset must abort side effects in the same cycle it is raised, not one cycle later.
  assign bus.req_ready = req_ready_c;
  assign bus.done      = done_c    && !reset;
  assign bus.we        = we_c      && !reset;
  assign bus.idx_we    = idx_we_c  && !reset;
  assign bus.tlbr_we   = tlbr_we_c && !reset;
  assign bus.mem_stall = probe_c   && !reset;

  assign bus.s1_vpn2     = bus.mem_stall ? ent_q.vpn2 : bus.mem_vpn2;
  assign bus.s1_asid     = bus.mem_stall ? ent_q.asid : bus.mem_asid;
  assign bus.s1_odd_page = bus.mem_stall ? 1'b0       : bus.mem_odd_page;

  assign bus.w_index = idx_q;
  assign bus.w_vpn2  = ent_q.vpn2;
  assign bus.w_asid  = ent_q.asid;
  assign bus.w_g     = ent_q.g;
  assign bus.w_pfn0  = ent_q.pfn0;
  assign bus.w_c0    = ent_q.c0;
  assign bus.w_d0    = ent_q.d0;
  assign bus.w_v0    = ent_q.v0;
  assign bus.w_pfn1  = ent_q.pfn1;
  assign bus.w_c1    = ent_q.c1;
  assign bus.w_d1    = ent_q.d1;
  assign bus.w_v1    = ent_q.v1;

  // Held through DONE so the array read data is stable when CP0 loads it.
  assign bus.r_index = idx_q;

  assign bus.idx_p     = !found_q;
  assign bus.idx_value = found_q ? pidx_q : '0;
  assign bus.random    = random_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small behavioural tlb array on the write and search ports.
module tb_tlb_op_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  tlb_op_ctrl_if #(.TLBNUM(16)) bus ();
  tlb_op_ctrl #(.TLBNUM(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [18:0] a_vpn2 [16];
  logic [7:0]  a_asid [16];
  logic        a_g    [16];
  logic [19:0] a_pfn0 [16];

  always @(posedge clk) begin
    if (bus.we) begin
      a_vpn2[bus.w_index] <= bus.w_vpn2;
      a_asid[bus.w_index] <= bus.w_asid;
      a_g[bus.w_index]    <= bus.w_g;
      a_pfn0[bus.w_index] <= bus.w_pfn0;
    end
  end

  always_comb begin
    bus.s1_found = 1'b0;
    bus.s1_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (a_vpn2[i] == bus.s1_vpn2 && (a_g[i] || a_asid[i] == bus.s1_asid)) begin
        bus.s1_found = 1'b1;
        bus.s1_index = 4'(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) begin
      a_vpn2[i] = '0; a_asid[i] = '0; a_g[i] = 1'b0; a_pfn0[i] = '0;
    end
    bus.req_valid = 1'b0; bus.req_op = 2'b00;
    bus.cp0_vpn2 = '0; bus.cp0_asid = '0; bus.cp0_g = 1'b0;
    bus.cp0_pfn0 = '0; bus.cp0_c0 = '0; bus.cp0_d0 = 1'b0; bus.cp0_v0 = 1'b0;
    bus.cp0_pfn1 = '0; bus.cp0_c1 = '0; bus.cp0_d1 = 1'b0; bus.cp0_v1 = 1'b0;
    bus.cp0_index = '0; bus.cp0_wired = '0; bus.wired_we = 1'b0;
    bus.mem_vpn2 = '0; bus.mem_odd_page = 1'b0; bus.mem_asid = '0;
    reset = 1'b1;
    step();
    n_checks++; if ({bus.done, bus.we, bus.idx_we, bus.tlbr_we, bus.mem_stall} !== 5'b0) begin n_fail++; $display("FAIL rst_outs_during: got %b want 00000", {bus.done, bus.we, bus.idx_we, bus.tlbr_we, bus.mem_stall}); end
    step();
    reset = 1'b0;
    #1;
    n_checks++; if (bus.random !== 4'd15) begin n_fail++; $display("FAIL rst_random: got %0d want 15", bus.random); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_checks++; if ({bus.done, bus.we, bus.idx_we, bus.tlbr_we, bus.mem_stall} !== 5'b0) begin n_fail++; $display("FAIL rst_outs_after: got %b want 00000", {bus.done, bus.we, bus.idx_we, bus.tlbr_we, bus.mem_stall}); end
  endtask

  task automatic test_tlbwi();
    bus.cp0_index = 4'd5; bus.cp0_vpn2 = 19'h12345; bus.cp0_asid = 8'h03; bus.cp0_g = 1'b0;
    bus.cp0_pfn0 = 20'hABCDE; bus.cp0_v0 = 1'b1; bus.cp0_pfn1 = 20'h13579;
    bus.req_op = 2'b10; bus.req_valid = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL wi_ready: got %b want 1", bus.req_ready); end
    step();
    bus.req_valid = 1'b0; bus.cp0_index = 4'd0; bus.cp0_pfn0 = 20'h0;
    #1;
    n_checks++; if (bus.we !== 1'b1) begin n_fail++; $display("FAIL wi_we: got %b want 1", bus.we); end
    n_checks++; if (bus.w_index !== 4'd5) begin n_fail++; $display("FAIL wi_index: got %0d want 5", bus.w_index); end
    n_checks++; if (bus.w_pfn0 !== 20'hABCDE) begin n_fail++; $display("FAIL wi_pfn0: got %h want abcde", bus.w_pfn0); end
    n_checks++; if (bus.w_vpn2 !== 19'h12345 || bus.w_asid !== 8'h03 || bus.w_pfn1 !== 20'h13579) begin n_fail++; $display("FAIL wi_fields: got %h/%h/%h want 12345/03/13579", bus.w_vpn2, bus.w_asid, bus.w_pfn1); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL wi_done_early: got %b want 0", bus.done); end
    step();
    n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL wi_we_one_cycle: got %b want 0", bus.we); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL wi_done: got %b want 1", bus.done); end
    n_checks++; if (a_vpn2[5] !== 19'h12345 || a_pfn0[5] !== 20'hABCDE) begin n_fail++; $display("FAIL wi_array: got %h/%h want 12345/abcde", a_vpn2[5], a_pfn0[5]); end
    step();
    n_checks++; if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL wi_idle: got done=%b rdy=%b want 0/1", bus.done, bus.req_ready); end
  endtask

  task automatic test_tlbp(input logic [7:0] asid, input logic exp_p, input logic [3:0] exp_v);
    bus.mem_vpn2 = 19'h0AAAA; bus.mem_asid = 8'h11; bus.mem_odd_page = 1'b1;
    bus.cp0_vpn2 = 19'h12345; bus.cp0_asid = asid; bus.req_op = 2'b00; bus.req_valid = 1'b1;
    #1;
    n_checks++; if (bus.s1_vpn2 !== 19'h0AAAA || bus.mem_stall !== 1'b0) begin n_fail++; $display("FAIL p_idle_pass: got vpn2=%h stall=%b want 0aaaa/0", bus.s1_vpn2, bus.mem_stall); end
    step();
    bus.req_valid = 1'b0; bus.cp0_vpn2 = 19'h7FFFF; bus.cp0_asid = 8'hEE;
    #1;
    n_checks++; if (bus.mem_stall !== 1'b1) begin n_fail++; $display("FAIL p_stall: got %b want 1", bus.mem_stall); end
    n_checks++; if (bus.s1_vpn2 !== 19'h12345 || bus.s1_asid !== asid || bus.s1_odd_page !== 1'b0) begin n_fail++; $display("FAIL p_s1: got %h/%h/%b want 12345/%h/0", bus.s1_vpn2, bus.s1_asid, bus.s1_odd_page, asid); end
    step();
    n_checks++; if (bus.done !== 1'b1 || bus.idx_we !== 1'b1) begin n_fail++; $display("FAIL p_done: got done=%b idx_we=%b want 1/1", bus.done, bus.idx_we); end
    n_checks++; if (bus.idx_p !== exp_p || bus.idx_value !== exp_v) begin n_fail++; $display("FAIL p_result: got p=%b val=%0d want %b/%0d", bus.idx_p, bus.idx_value, exp_p, exp_v); end
    n_checks++; if (bus.mem_stall !== 1'b0 || bus.s1_vpn2 !== 19'h0AAAA || bus.s1_odd_page !== 1'b1) begin n_fail++; $display("FAIL p_done_pass: got stall=%b vpn2=%h odd=%b want 0/0aaaa/1", bus.mem_stall, bus.s1_vpn2, bus.s1_odd_page); end
    step();
    n_checks++; if (bus.idx_we !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL p_idle: got idx_we=%b done=%b want 0/0", bus.idx_we, bus.done); end
  endtask

  task automatic test_tlbr();
    bus.cp0_index = 4'd5; bus.req_op = 2'b01; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0; bus.cp0_index = 4'd2;
    #1;
    n_checks++; if (bus.r_index !== 4'd5) begin n_fail++; $display("FAIL r_index_read: got %0d want 5", bus.r_index); end
    n_checks++; if (bus.tlbr_we !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL r_early: got tlbr_we=%b done=%b want 0/0", bus.tlbr_we, bus.done); end
    step();
    n_checks++; if (bus.r_index !== 4'd5) begin n_fail++; $display("FAIL r_index_done: got %0d want 5", bus.r_index); end
    n_checks++; if (bus.tlbr_we !== 1'b1 || bus.done !== 1'b1 || bus.idx_we !== 1'b0) begin n_fail++; $display("FAIL r_done: got tlbr_we=%b done=%b idx_we=%b want 1/1/0", bus.tlbr_we, bus.done, bus.idx_we); end
    step();
    n_checks++; if (bus.tlbr_we !== 1'b0) begin n_fail++; $display("FAIL r_idle: got %b want 0", bus.tlbr_we); end
  endtask

  task automatic test_random_tlbwr();
    int k;
    logic [3:0] exp;
    bus.cp0_wired = 4'd4; bus.wired_we = 1'b1;
    step();
    bus.wired_we = 1'b0;
    for (int i = 0; i < 13; i++) begin
      exp = (i < 12) ? 4'(15 - i) : 4'd15;
      n_checks++; if (bus.random !== exp) begin n_fail++; $display("FAIL rand_seq[%0d]: got %0d want %0d", i, bus.random, exp); end
      step();
    end
    k = 0;
    while (bus.random !== 4'd9 && k < 20) begin step(); k++; end
    n_checks++; if (k >= 20) begin n_fail++; $display("FAIL rand_wait9: got timeout want random=9"); end
    bus.wired_we = 1'b1;
    step();
    bus.wired_we = 1'b0;
    n_checks++; if (bus.random !== 4'd15) begin n_fail++; $display("FAIL rand_wired_we: got %0d want 15", bus.random); end
    k = 0;
    while (bus.random !== 4'd7 && k < 20) begin step(); k++; end
    n_checks++; if (k >= 20) begin n_fail++; $display("FAIL rand_wait7: got timeout want random=7"); end
    bus.cp0_index = 4'd3; bus.cp0_vpn2 = 19'h00777; bus.cp0_asid = 8'h01; bus.cp0_g = 1'b1;
    bus.req_op = 2'b11; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0; bus.cp0_g = 1'b0;
    #1;
    n_checks++; if (bus.we !== 1'b1 || bus.w_index !== 4'd7 || bus.w_g !== 1'b1) begin n_fail++; $display("FAIL wr_write: got we=%b idx=%0d g=%b want 1/7/1", bus.we, bus.w_index, bus.w_g); end
    n_checks++; if (bus.random !== 4'd6) begin n_fail++; $display("FAIL wr_random_moves: got %0d want 6", bus.random); end
    step();
    n_checks++; if (bus.done !== 1'b1 || bus.w_index !== 4'd7) begin n_fail++; $display("FAIL wr_done: got done=%b idx=%0d want 1/7", bus.done, bus.w_index); end
    step();
  endtask

  task automatic test_back_to_back();
    bus.cp0_index = 4'd9; bus.cp0_vpn2 = 19'h01234; bus.cp0_asid = 8'h22; bus.cp0_g = 1'b0;
    bus.req_op = 2'b10; bus.req_valid = 1'b1;
    step();
    bus.req_op = 2'b00;
    #1;
    n_checks++; if (bus.req_ready !== 1'b0 || bus.we !== 1'b1) begin n_fail++; $display("FAIL b2b_write: got rdy=%b we=%b want 0/1", bus.req_ready, bus.we); end
    step();
    n_checks++; if (bus.req_ready !== 1'b0 || bus.mem_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got rdy=%b stall=%b want 0/0", bus.req_ready, bus.mem_stall); end
    step();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", bus.req_ready); end
    step();
    bus.req_valid = 1'b0;
    #1;
    n_checks++; if (bus.mem_stall !== 1'b1 || bus.s1_vpn2 !== 19'h01234) begin n_fail++; $display("FAIL b2b_probe: got stall=%b vpn2=%h want 1/01234", bus.mem_stall, bus.s1_vpn2); end
    step();
    n_checks++; if (bus.idx_we !== 1'b1 || bus.idx_p !== 1'b0 || bus.idx_value !== 4'd9) begin n_fail++; $display("FAIL b2b_hit: got we=%b p=%b val=%0d want 1/0/9", bus.idx_we, bus.idx_p, bus.idx_value); end
    step();
  endtask

  task automatic test_reset_in_write();
    bus.cp0_index = 4'd5; bus.cp0_vpn2 = 19'h55555; bus.cp0_asid = 8'h07;
    bus.req_op = 2'b10; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    #1;
    n_checks++; if (bus.we !== 1'b1) begin n_fail++; $display("FAIL rw_pre: got we=%b want 1", bus.we); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.we !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rw_we_gated: got we=%b done=%b want 0/0", bus.we, bus.done); end
    step();
    n_checks++; if (a_vpn2[5] !== 19'h12345) begin n_fail++; $display("FAIL rw_array: got %h want 12345", a_vpn2[5]); end
    n_checks++; if (bus.req_ready !== 1'b1 || bus.random !== 4'd15 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rw_state: got rdy=%b rand=%0d done=%b want 1/15/0", bus.req_ready, bus.random, bus.done); end
    reset = 1'b0;
    step();
    n_checks++; if (bus.done !== 1'b0 || bus.we !== 1'b0) begin n_fail++; $display("FAIL rw_after: got done=%b we=%b want 0/0", bus.done, bus.we); end
  endtask

  initial begin
    test_reset();
    test_tlbwi();
    test_tlbp(8'h03, 1'b0, 4'd5);
    test_tlbp(8'h04, 1'b1, 4'd0);
    test_tlbr();
    test_random_tlbwr();
    test_back_to_back();
    test_reset_in_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
